// File: rtl/apsk_llr_minsearch.sv
// -----------------------------------------------------------------------------
// ApskLlrMinsearch : max-log LLR back end of the exhaustive APSK demapper.
//
// Sits directly downstream of the metric unit. Each accepted beat carries one
// squared-distance metric (Q8.10) and the bit label of the candidate point it
// belongs to. For every bit position the block keeps the smallest metric seen
// among candidates whose label has that bit at 0 and among those with it at 1.
// When the sweep ends it emits LLR[b] = min1[b] - min0[b], so a positive LLR
// favours bit 0. 16-, 32- and 64-APSK sweeps are supported.
//
// Ports
//   clk          clock
//   rst_n        synchronous active-low reset
//   mode_i       0=16APSK (4 bits), 1=32APSK (5 bits), 2/3=64APSK (6 bits);
//                sampled on the first beat of a sweep
//   metric_i     candidate metric, >= 0; 0x1FFFF means infinite
//   label_i      candidate bit label, aligned to metric_i
//   valid_i      metric_i/label_i/first_i/last_i qualified this cycle
//   first_i      first candidate of a symbol sweep
//   last_i       last candidate of a symbol sweep
//   llr_o        packed LLRs, bit b at [b*WL +: WL]; held until the next pulse
//   llr_valid_o  one-cycle pulse, one cycle after the last beat
//   cnt_err_o    pulses with llr_valid_o if the beat count != 2^nbits
//   busy_o       high while a sweep is being accumulated
// -----------------------------------------------------------------------------
module apsk_llr_minsearch #(
  parameter int WL      = 18,
  parameter int MAXBITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            mode_i,
  input  logic [WL-1:0]         metric_i,
  input  logic [MAXBITS-1:0]    label_i,
  input  logic                  valid_i,
  input  logic                  first_i,
  input  logic                  last_i,
  output logic [MAXBITS*WL-1:0] llr_o,
  output logic                  llr_valid_o,
  output logic                  cnt_err_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_e;

  localparam logic [WL-1:0] INF = {1'b0, {(WL-1){1'b1}}};

  state_e                     state_q, state_d;
  logic [1:0]                 mode_q, mode_d;
  logic [6:0]                 cnt_q, cnt_d;
  logic [MAXBITS-1:0][WL-1:0] min0_q, min0_d;
  logic [MAXBITS-1:0][WL-1:0] min1_q, min1_d;
  logic [MAXBITS*WL-1:0]      llr_q, llr_d;
  logic                       llrValid_q, llrValid_d;
  logic                       cntErr_q, cntErr_d;

  logic                       startBeat;
  logic                       contBeat;
  logic                       endSweep;
  logic [1:0]                 modeEff;
  int                         nbits;
  logic [MAXBITS-1:0]         bitMask;
  logic [6:0]                 expBeats;

  // A first beat starts (or restarts) a sweep from any state; a non-first beat
  // only counts while accumulating. The mode used for this beat is the freshly
  // presented one on a first beat so single-beat sweeps see the right width.
  always_comb begin
    startBeat = valid_i & first_i;
    contBeat  = valid_i & ~first_i & (state_q == ACC);
    endSweep  = (startBeat | contBeat) & last_i;
    modeEff   = startBeat ? mode_i : mode_q;
    unique case (modeEff)
      2'd0:    begin nbits = 4; expBeats = 7'd16; end
      2'd1:    begin nbits = 5; expBeats = 7'd32; end
      default: begin nbits = 6; expBeats = 7'd64; end
    endcase
    for (int b = 0; b < MAXBITS; b++) begin
      bitMask[b] = (b < nbits);
    end
  end

  // Next-state logic. A sweep ending always lands in OUT, including a
  // first&last beat arriving in any state; OUT otherwise lasts one cycle.
  always_comb begin
    state_d = state_q;
    if (endSweep) begin
      state_d = OUT;
    end else if (startBeat) begin
      state_d = ACC;
    end else if (state_q == OUT) begin
      state_d = IDLE;
    end
  end

  // Datapath: per-bit minimum tracking, beat counting and LLR formation. The
  // LLR is built from the next-state minima so the last beat is included.
  // A polarity never seen keeps INF, and INF - metric still fits in WL bits.
  always_comb begin
    min0_d = min0_q;
    min1_d = min1_q;
    mode_d = startBeat ? mode_i : mode_q;
    cnt_d  = cnt_q;
    if (startBeat) begin
      cnt_d = 7'd1;
    end else if (contBeat && (cnt_q != 7'd127)) begin
      cnt_d = cnt_q + 7'd1;
    end
    for (int b = 0; b < MAXBITS; b++) begin
      if (startBeat) begin
        min0_d[b] = (bitMask[b] && !label_i[b]) ? metric_i : INF;
        min1_d[b] = (bitMask[b] &&  label_i[b]) ? metric_i : INF;
      end else if (contBeat && bitMask[b]) begin
        if (label_i[b]) begin
          if (metric_i < min1_q[b]) min1_d[b] = metric_i;
        end else begin
          if (metric_i < min0_q[b]) min0_d[b] = metric_i;
        end
      end
    end
    llr_d = llr_q;
    if (endSweep) begin
      for (int b = 0; b < MAXBITS; b++) begin
        llr_d[b*WL +: WL] = bitMask[b] ? (min1_d[b] - min0_d[b]) : '0;
      end
    end
    llrValid_d = endSweep;
    cntErr_d   = endSweep && (cnt_d != expBeats);
  end

  // State and datapath registers; reset discards any sweep in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= 2'd0;
      cnt_q      <= 7'd0;
      min0_q     <= {MAXBITS{INF}};
      min1_q     <= {MAXBITS{INF}};
      llr_q      <= '0;
      llrValid_q <= 1'b0;
      cntErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      min0_q     <= min0_d;
      min1_q     <= min1_d;
      llr_q      <= llr_d;
      llrValid_q <= llrValid_d;
      cntErr_q   <= cntErr_d;
    end
  end

  assign llr_o       = llr_q;
  assign llr_valid_o = llrValid_q;
  assign cnt_err_o   = cntErr_q;
  assign busy_o      = (state_q == ACC);

endmodule

// File: tb/tb_apsk_llr_minsearch.sv
// -----------------------------------------------------------------------------
// Testbench for apsk_llr_minsearch. A behavioural model records the beats of
// the current sweep in a queue and, when the sweep ends, derives each bit's
// LLR from plain minimum searches over that queue. Outputs are compared
// against the model on every falling edge; literal checks pin key results.
// -----------------------------------------------------------------------------
module tb_apsk_llr_minsearch;

  localparam int WL      = 18;
  localparam int MAXBITS = 6;
  localparam logic [WL-1:0] INF = 18'h1FFFF;

  logic                  clk;
  logic                  rst_n;
  logic [1:0]            mode_i;
  logic [WL-1:0]         metric_i;
  logic [MAXBITS-1:0]    label_i;
  logic                  valid_i;
  logic                  first_i;
  logic                  last_i;
  logic [MAXBITS*WL-1:0] llr_o;
  logic                  llr_valid_o;
  logic                  cnt_err_o;
  logic                  busy_o;

  int vectors     = 0;
  int miscompares = 0;
  int pulseCount  = 0;

  apsk_llr_minsearch #(.WL(WL), .MAXBITS(MAXBITS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode_i      (mode_i),
    .metric_i    (metric_i),
    .label_i     (label_i),
    .valid_i     (valid_i),
    .first_i     (first_i),
    .last_i      (last_i),
    .llr_o       (llr_o),
    .llr_valid_o (llr_valid_o),
    .cnt_err_o   (cnt_err_o),
    .busy_o      (busy_o)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [MAXBITS-1:0] label;
    logic [WL-1:0]      metric;
  } beat_t;

  beat_t                 beats[$];
  logic                  inSweep   = 1'b0;
  logic [1:0]            sweepMode = 2'd0;
  logic [MAXBITS*WL-1:0] expLlr    = '0;
  logic                  expValid  = 1'b0;
  logic                  expErr    = 1'b0;
  logic                  expBusy   = 1'b0;
  logic [WL-1:0]         m0, m1;
  int                    nb;

  task automatic checkOutput(input string name, input logic [MAXBITS*WL-1:0] got,
                             input logic [MAXBITS*WL-1:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, got, want);
    end
  endtask

  // Reference model: collect the sweep's beats, then evaluate each bit's
  // minima by a direct search when the last beat arrives.
  always @(posedge clk) begin
    expValid = 1'b0;
    expErr   = 1'b0;
    if (!rst_n) begin
      beats.delete();
      inSweep = 1'b0;
      expLlr  = '0;
    end else if (valid_i && (first_i || inSweep)) begin
      if (first_i) begin
        beats.delete();
        sweepMode = mode_i;
      end
      beats.push_back('{label: label_i, metric: metric_i});
      inSweep = 1'b1;
      if (last_i) begin
        nb = (sweepMode == 2'd0) ? 4 : (sweepMode == 2'd1) ? 5 : 6;
        for (int b = 0; b < MAXBITS; b++) begin
          m0 = INF;
          m1 = INF;
          foreach (beats[i]) begin
            if (beats[i].label[b] && beats[i].metric < m1) m1 = beats[i].metric;
            if (!beats[i].label[b] && beats[i].metric < m0) m0 = beats[i].metric;
          end
          expLlr[b*WL +: WL] = (b < nb) ? WL'(m1 - m0) : '0;
        end
        expValid = 1'b1;
        expErr   = (beats.size() != (1 << nb));
        inSweep  = 1'b0;
      end
    end
    expBusy = inSweep;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    checkOutput("llr_valid", {107'd0, llr_valid_o}, {107'd0, expValid});
    checkOutput("cnt_err",   {107'd0, cnt_err_o},   {107'd0, expErr});
    checkOutput("busy",      {107'd0, busy_o},      {107'd0, expBusy});
    checkOutput("llr",       llr_o,                 expLlr);
    if (llr_valid_o === 1'b1) pulseCount++;
  end

  task automatic applyStimulus(input logic v, input logic f, input logic l,
                               input logic [1:0] md, input logic [MAXBITS-1:0] lab,
                               input logic [WL-1:0] met);
    valid_i  = v;
    first_i  = f;
    last_i   = l;
    mode_i   = md;
    label_i  = lab;
    metric_i = met;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, '0, '0);
  endtask

  int pc0;

  initial begin
    rst_n = 1'b0;
    valid_i = 1'b0; first_i = 1'b0; last_i = 1'b0;
    mode_i = 2'd0; label_i = '0; metric_i = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_llr",   llr_o,                   '0);
    checkOutput("reset_valid", {107'd0, llr_valid_o},   '0);
    checkOutput("reset_busy",  {107'd0, busy_o},        '0);
    rst_n = 1'b1;

    // Non-first beat while idle is ignored
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd0, 6'd3, 18'h00010);
    idle(1);
    checkOutput("stray_busy", {107'd0, busy_o}, '0);

    // 16-APSK, label 5 closest; high label bits must not matter
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, i == 0, i == 15, 2'd0, {2'b10, 4'(i)}, (i == 5) ? 18'h0 : 18'h00400);
    checkOutput("t1_valid", {107'd0, llr_valid_o}, 108'd1);
    checkOutput("t1_err",   {107'd0, cnt_err_o},   '0);
    checkOutput("t1_llr",   llr_o,  {18'h0, 18'h0, 18'h00400, 18'h3FC00, 18'h00400, 18'h3FC00});
    checkOutput("t1_model", expLlr, {18'h0, 18'h0, 18'h00400, 18'h3FC00, 18'h00400, 18'h3FC00});
    idle(2);

    // 64-APSK, metric grows with label, with an idle gap mid-sweep
    for (int i = 0; i < 64; i++) begin
      if (i == 30) idle(1);
      applyStimulus(1'b1, i == 0, i == 63, 2'd2, 6'(i), 18'(i * 16));
    end
    checkOutput("t2_llr", llr_o, {18'h200, 18'h100, 18'h080, 18'h040, 18'h020, 18'h010});
    checkOutput("t2_err", {107'd0, cnt_err_o}, '0);
    idle(2);

    // 32-APSK with a wrong beat count
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b1, i == 0, i == 19, 2'd1, 6'(i), 18'(100 + 3 * i));
    checkOutput("t3_valid", {107'd0, llr_valid_o}, 108'd1);
    checkOutput("t3_err",   {107'd0, cnt_err_o},   108'd1);
    idle(2);

    // Back-to-back sweeps, second starts in the output cycle of the first
    pc0 = pulseCount;
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, i == 0, i == 15, 2'd0, 6'(i), 18'((i * 37) & 18'h3FF));
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, i == 0, i == 15, 2'd0, 6'(i), 18'((15 - i) * 8));
    checkOutput("t4_llr", llr_o, {18'h0, 18'h0, 18'h3FFC0, 18'h3FFE0, 18'h3FFF0, 18'h3FFF8});
    idle(1);
    checkOutput("t4_pulses", 108'(pulseCount - pc0), 108'd2);
    idle(1);

    // Restart at beat 7: only the restarted sweep reports
    pc0 = pulseCount;
    for (int i = 0; i < 7; i++)
      applyStimulus(1'b1, i == 0, 1'b0, 2'd2, 6'(i), 18'h00001);
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, i == 0, i == 15, 2'd0, 6'(i), (i == 5) ? 18'h0 : 18'h00400);
    checkOutput("t5_llr", llr_o, {18'h0, 18'h0, 18'h00400, 18'h3FC00, 18'h00400, 18'h3FC00});
    checkOutput("t5_err", {107'd0, cnt_err_o}, '0);
    idle(1);
    checkOutput("t5_pulses", 108'(pulseCount - pc0), 108'd1);

    // Reset mid-sweep: the remaining beats are ignored, no output
    pc0 = pulseCount;
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, i == 0, 1'b0, 2'd0, 6'(i), 18'h00020);
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 6'd5, 18'h00020);
    rst_n = 1'b1;
    for (int i = 6; i < 16; i++)
      applyStimulus(1'b1, 1'b0, i == 15, 2'd0, 6'(i), 18'h00020);
    idle(2);
    checkOutput("t5_rst_pulses", 108'(pulseCount - pc0), '0);
    checkOutput("t5_rst_llr",    llr_o, '0);
    checkOutput("t5_rst_busy",   {107'd0, busy_o}, '0);

    // Equal metrics on every 32-APSK label
    for (int i = 0; i < 32; i++)
      applyStimulus(1'b1, i == 0, i == 31, 2'd1, 6'(i), 18'h00200);
    checkOutput("t6_eq_llr", llr_o, '0);
    checkOutput("t6_eq_err", {107'd0, cnt_err_o}, '0);
    idle(1);

    // Single-beat sweep: unseen polarity stays infinite
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 6'd0, 18'h00100);
    checkOutput("t6_one_llr", llr_o, {18'h0, 18'h0, 18'h1FEFF, 18'h1FEFF, 18'h1FEFF, 18'h1FEFF});
    checkOutput("t6_one_err", {107'd0, cnt_err_o}, 108'd1);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
